lcd_cmd_issuer: RTL and testbench

LCD_CMD_ISSUER -- requirements
Module: lcd_cmd_issuer

---
 rtl/lcd_cmd_issuer.sv | 170 +++++++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_issuer.sv
// lcd_cmd_issuer: walks a 32-entry command memory and hands each command to
// an LCD controller, one strobe per command, until an end marker (>7), a
// write-back command (0, completed by done), or the last address.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            one-cycle pulse that begins a sequence (only honoured in IDLE)
//   cmdmem_rd/_A/_Q  command-memory read strobe, address, data (data valid the cycle after rd)
//   busy, done       controller busy level and write-back-complete pulse
//   cmd, cmd_valid   command and one-cycle strobe to the controller
//   seq_done         sequence finished, held until the next start
//   cmd_count        commands issued in the current sequence (saturates at 63)
//   timeout          watchdog expired
//
// Optional feature: define LCD_ISSUER_TIMEOUT_EN to enable an 8-bit watchdog
// on the ISSUE and WAIT states; otherwise timeout is constant 0.
module lcd_cmd_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       cmdmem_rd,
    output logic [4:0] cmdmem_A,
    input  logic [3:0] cmdmem_Q,
    input  logic       busy,
    input  logic       done,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       seq_done,
    output logic [5:0] cmd_count,
    output logic       timeout
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned CNT_W  = 6;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LATCH  = 3'd2;
    localparam logic [2:0] ISSUE  = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] WAIT   = 3'd5;
    localparam logic [2:0] FINISH = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(31);
    localparam logic [CMD_W-1:0]  MAX_CMD   = CMD_W'(7);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(63);

    logic [2:0]        state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [CMD_W-1:0]  cmd_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              rd_n, valid_n, sd_n, to_n;
    logic              wd_exp;

`ifdef LCD_ISSUER_TIMEOUT_EN
    localparam int unsigned WD_W = 8;
    logic [WD_W-1:0] wdog, wdog_n;

    // Expires on the cycle the count would reach 255.
    assign wd_exp = (wdog == WD_W'(254));

    // Watchdog restarts on every state change and only counts the waiting states.
    always_comb begin
        wdog_n = '0;
        if (state_n == state && (state == ISSUE || state == WAIT)) begin
            wdog_n = wdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_n;
        end
    end
`else
    assign wd_exp = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_n = state;
        addr_n  = cmdmem_A;
        cmd_n   = cmd;
        cnt_n   = cmd_count;
        sd_n    = seq_done;
        to_n    = timeout;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_n  = '0;
                    cnt_n   = '0;
                    sd_n    = 1'b0;
                    to_n    = 1'b0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                cmd_n   = cmdmem_Q;
                state_n = (cmdmem_Q > MAX_CMD) ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (wd_exp) begin
                    to_n    = 1'b1;
                    state_n = FINISH;
                end else if (!busy) begin
                    valid_n = 1'b1;
                    if (cmd_count != CNT_MAX) begin
                        cnt_n = cmd_count + CNT_W'(1);
                    end
                    state_n = HOLD;
                end
            end
            HOLD: state_n = WAIT;
            WAIT: begin
                if (wd_exp) begin
                    to_n    = 1'b1;
                    state_n = FINISH;
                end else if (cmd == '0) begin
                    // Write-back: completion is signalled by done, not busy.
                    if (done) begin
                        state_n = FINISH;
                    end
                end else if (!busy) begin
                    if (cmdmem_A == LAST_ADDR) begin
                        state_n = FINISH;
                    end else begin
                        addr_n  = cmdmem_A + ADDR_W'(1);
                        state_n = FETCH;
                    end
                end
            end
            FINISH: begin
                sd_n    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Read strobe is high for exactly the cycle spent in FETCH.
        rd_n = (state_n == FETCH);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmdmem_rd <= 1'b0;
            cmdmem_A  <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            cmd_count <= '0;
            seq_done  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            cmdmem_rd <= rd_n;
            cmdmem_A  <= addr_n;
            cmd       <= cmd_n;
            cmd_valid <= valid_n;
            cmd_count <= cnt_n;
            seq_done  <= sd_n;
            timeout   <= to_n;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// tb_lcd_cmd_issuer: self-checking bench for lcd_cmd_issuer with a command
// memory model, a randomized controller model and a list-level reference.
// Honours LCD_ISSUER_TIMEOUT_EN in the same way as the design.
module tb_lcd_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cmdmem_rd;
    logic [4:0] cmdmem_A;
    logic [3:0] cmdmem_Q = 4'h0;
    logic       busy;
    logic       done;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       seq_done;
    logic [5:0] cmd_count;
    logic       timeout;

    lcd_cmd_issuer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmdmem_rd (cmdmem_rd),
        .cmdmem_A  (cmdmem_A),
        .cmdmem_Q  (cmdmem_Q),
        .busy      (busy),
        .done      (done),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .seq_done  (seq_done),
        .cmd_count (cmd_count),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Command memory: data appears the cycle after the read strobe.
    logic [3:0] mem [32];
    always @(posedge clk) begin
        if (cmdmem_rd) cmdmem_Q <= mem[cmdmem_A];
    end

    // Controller: either manual busy, or a model that goes busy 1..3 cycles
    // after each strobe (done pulse at the end of a write-back) and otherwise
    // raises random idle stalls.
    logic ctrl_en = 1'b0;
    logic man_busy = 1'b0;
    logic mdl_busy = 1'b0;
    logic mdl_done = 1'b0;
    int   mdl_cnt = 0;
    logic mdl_pend = 1'b0;
    assign busy = ctrl_en ? mdl_busy : man_busy;
    assign done = ctrl_en & mdl_done;

    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (!ctrl_en) begin
            mdl_cnt  = 0;
            mdl_pend = 1'b0;
            mdl_busy = 1'b0;
        end else if (cmd_valid) begin
            mdl_busy = 1'b1;
            mdl_cnt  = int'($urandom_range(1, 3));
            mdl_pend = (cmd == 4'd0);
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                mdl_busy = 1'b0;
                if (mdl_pend) begin
                    mdl_done = 1'b1;
                    mdl_pend = 1'b0;
                end
            end
        end else begin
            mdl_busy = ($urandom_range(0, 3) == 0);
        end
    end

    // Strobe monitor: records issued commands, checks one-cycle strobes and
    // that cmd is unchanged in the cycle after the strobe.
    logic [3:0] obs [$];
    logic       prev_v = 1'b0;
    logic       hold_pend = 1'b0;
    logic [3:0] hold_cmd = 4'h0;
    always @(negedge clk) begin
        if (hold_pend) begin
            chk("cmd_hold", 32'(cmd), 32'(hold_cmd));
            hold_pend = 1'b0;
        end
        if (cmd_valid) begin
            chk("strobe_width", 32'(prev_v), 32'd0);
            obs.push_back(cmd);
            hold_pend = 1'b1;
            hold_cmd  = cmd;
        end
        prev_v = cmd_valid;
    end

    // Reference: walk the list by the rules (stop at >7 without issuing, stop
    // after issuing 0, stop after entry 31).
    logic [3:0] exp_q [$];
    logic [4:0] exp_a;
    function automatic void ref_model();
        exp_q.delete();
        exp_a = 5'd0;
        for (int i = 0; i < 32; i++) begin
            exp_a = 5'(i);
            if (mem[i] > 4'd7) break;
            exp_q.push_back(mem[i]);
            if (mem[i] == 4'd0) break;
        end
    endfunction

    task automatic run_seq(input string name, input int max_cyc);
        int n;
        obs.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!seq_done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_seq_done"}, 32'(seq_done), 32'd1);
    endtask

    task automatic check_result(input string name);
        chk({name, "_nstrobes"}, 32'(obs.size()), 32'(exp_q.size()));
        chk({name, "_cmd_count"}, 32'(cmd_count), 32'(exp_q.size()));
        chk({name, "_addr"}, 32'(cmdmem_A), 32'(exp_a));
        chk({name, "_timeout"}, 32'(timeout), 32'd0);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk({name, "_cmd"}, 32'(obs[i]), 32'(exp_q[i]));
        end
    endtask

    typedef struct {
        logic [7:0][3:0] head;   // entries 0..7 (entry 0 in the low nibble), rest = 15
        int unsigned     exp_cnt;
        logic [4:0]      exp_a;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 4'hF;
        vecs[0] = '{32'hFFFF_0544, 4, 5'd3};  // 4,4,5,0
        vecs[1] = '{32'hFFFF_FFF7, 1, 5'd1};  // 7, end marker
        vecs[2] = '{32'hFFFF_FFFF, 0, 5'd0};  // immediate end marker
        vecs[3] = '{32'hFFFF_FFF0, 1, 5'd0};  // lone write-back
        vecs[4] = '{32'h0765_4321, 8, 5'd7};  // 1..7 then write-back
        vecs[5] = '{32'hFFFF_FF83, 1, 5'd1};  // 3, marker 8

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmdmem_rd", 32'(cmdmem_rd), 32'd0);
        chk("rst_addr", 32'(cmdmem_A), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_count", 32'(cmd_count), 32'd0);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_autostart", 32'(cmdmem_rd), 32'd0);

        // Latency: strobe three cycles after start with busy low.
        mem[0] = 4'd6;
        mem[1] = 4'hF;
        ctrl_en = 1'b0;
        man_busy = 1'b0;
        obs.delete();
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("latency_valid", 32'(cmd_valid), (k == 4) ? 32'd1 : 32'd0);
            if (k == 1) chk("fetch_rd", 32'(cmdmem_rd), 32'd1);
        end
        n = 0;
        while (!seq_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        ref_model();
        chk("latency_seq_done", 32'(seq_done), 32'd1);
        check_result("latency");

        // Directed table.
        ctrl_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 32; i++) mem[i] = (i < 8) ? vecs[v].head[i] : 4'hF;
            ref_model();
            run_seq("table", 500);
            chk("table_cmd_count", 32'(cmd_count), 32'(vecs[v].exp_cnt));
            chk("table_addr", 32'(cmdmem_A), 32'(vecs[v].exp_a));
            check_result("table_ref");
            @(negedge clk);
        end

        // Address limit: all 32 entries are plain commands.
        for (int i = 0; i < 32; i++) mem[i] = 4'd1;
        ref_model();
        run_seq("addr_limit", 2000);
        chk("addr_limit_strobes", 32'(obs.size()), 32'd32);
        chk("addr_limit_addr", 32'(cmdmem_A), 32'd31);
        check_result("addr_limit");
        repeat (5) @(negedge clk);
        chk("addr_limit_no_restart", 32'(obs.size()), 32'd32);

        // Random lists against the reference.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) begin
                int r;
                r = int'($urandom_range(0, 15));
                if (r < 13) mem[i] = 4'($urandom_range(1, 7));
                else if (r == 13) mem[i] = 4'd0;
                else mem[i] = 4'($urandom_range(8, 15));
            end
            ref_model();
            run_seq("rand", 2000);
            check_result("rand");
            @(negedge clk);
        end

        // Busy stall in ISSUE, with an ignored start in the middle.
        ctrl_en = 1'b0;
        man_busy = 1'b1;
        mem[0] = 4'd2;
        mem[1] = 4'hF;
        ref_model();
        obs.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 22; k++) begin
            start = (k == 10);
            @(negedge clk);
            if (cmd_valid) chk("stall_no_valid", 32'(cmd_valid), 32'd0);
        end
        start = 1'b0;
        chk("stall_none_yet", 32'(obs.size()), 32'd0);
        man_busy = 1'b0;
        @(negedge clk);
        chk("stall_release_valid", 32'(cmd_valid), 32'd1);
        chk("stall_release_cmd", 32'(cmd), 32'd2);
        @(negedge clk);
        chk("stall_valid_drop", 32'(cmd_valid), 32'd0);
        chk("stall_cmd_held", 32'(cmd), 32'd2);
        n = 0;
        while (!seq_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_seq_done", 32'(seq_done), 32'd1);
        check_result("stall");

        // Reset while waiting on the second command.
        mem[0] = 4'd3;
        mem[1] = 4'd2;
        mem[2] = 4'hF;
        man_busy = 1'b0;
        obs.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (obs.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait_reached", 32'(obs.size()), 32'd2);
        man_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstwait_addr_before", 32'(cmdmem_A), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstwait_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rstwait_cmdmem_rd", 32'(cmdmem_rd), 32'd0);
        chk("rstwait_addr", 32'(cmdmem_A), 32'd0);
        chk("rstwait_cmd", 32'(cmd), 32'd0);
        chk("rstwait_cmd_count", 32'(cmd_count), 32'd0);
        chk("rstwait_seq_done", 32'(seq_done), 32'd0);
        chk("rstwait_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        man_busy = 1'b0;
        obs.delete();
        repeat (10) @(negedge clk);
        chk("rstwait_no_strobe", 32'(obs.size()), 32'd0);
        chk("rstwait_no_finish", 32'(seq_done), 32'd0);

        // Busy stuck high in ISSUE.
        mem[0] = 4'd5;
        mem[1] = 4'hF;
        man_busy = 1'b1;
        obs.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef LCD_ISSUER_TIMEOUT_EN
        n = 0;
        while (!seq_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_seq_done", 32'(seq_done), 32'd1);
        chk("wdog_timeout", 32'(timeout), 32'd1);
        chk("wdog_latency_window", 32'(n >= 255 && n <= 262), 32'd1);
        chk("wdog_no_strobe", 32'(obs.size()), 32'd0);
        chk("wdog_cmd_count", 32'(cmd_count), 32'd0);
`else
        repeat (300) @(negedge clk);
        chk("stuck_timeout", 32'(timeout), 32'd0);
        chk("stuck_seq_done", 32'(seq_done), 32'd0);
        chk("stuck_no_strobe", 32'(obs.size()), 32'd0);
        man_busy = 1'b0;
        n = 0;
        while (!seq_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        ref_model();
        chk("stuck_seq_done_late", 32'(seq_done), 32'd1);
        check_result("stuck");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
